uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver. It sits directly downstream of the UART transmitter and consumes its TX_OUT line. The block oversamples RX_IN, detects the start bit, and shifts in Data_Width bits LSB-first. It checks the optional parity bit and the stop bit, then presents the byte on a parallel bus with a one-cycle valid strobe plus error flags. Frame format matches the transmitter: idle 1, start 0, data LSB-first, optional parity, one stop bit (1).

Parameters:
Data_Width, 8, number of data bits per frame
Prescale, 8, CLK cycles per bit period; even, >= 4
Counter_Width, 3, width of the data-bit index counter; must satisfy 2^Counter_Width >= Data_Width

Ports:
CLK  input  1  system clock; one bit period = Prescale CLK cycles
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line; asynchronous to CLK; idles high
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  Data_Width  last correctly received data word
Data_Valid  output  1  one-cycle strobe when P_DATA is updated
PAR_ERR  output  1  one-cycle strobe: parity mismatch on the frame just ended
STP_ERR  output  1  one-cycle strobe: stop bit sampled as 0

Behaviour:
- Reset (asynchronous, RST=1): FSM goes to IDLE; all counters are 0. P_DATA=0, Data_Valid=0, PAR_ERR=0, STP_ERR=0. The synchronizer flops are set to 1 (line idle).
- RX_IN passes through a 2-flop synchronizer (rx_s). All latencies below are measured from rx_s.
- Tick counter: counts 0..Prescale-1 within each bit period and wraps to 0. The bit index counter advances on the wrap.
- Bit sample: majority vote of rx_s taken at tick counts Prescale/2-1, Prescale/2 and Prescale/2+1. The sampled value is valid from tick Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s=0, go to START with tick=0. Latch PAR_EN and PAR_TYP at this point; the latched values hold for the whole frame.
  - START: at tick Prescale-1, go to DATA if the start sample is 0. If the sample is 1 (glitch), return to IDLE; no strobes are raised.
  - DATA: shift each sample into the MSB of the shift register (LSB-first reception). After Data_Width bits, go to PARITY if PAR_EN is latched, otherwise to STOP.
  - PARITY: compare the sample against the XOR of the data, inverted when PAR_TYP=1. Record the mismatch. Go to STOP.
  - STOP: at tick Prescale/2+2, evaluate the sample.
    - The next cycle returns to IDLE, so back-to-back frames are accepted with no gap.
    - In that same next cycle exactly one outcome occurs:
      - Data_Valid=1 for one cycle and P_DATA loaded, if stop=1 and there is no parity error.
      - Otherwise, PAR_ERR and/or STP_ERR=1 for one cycle, Data_Valid stays 0, and P_DATA is unchanged.
- PAR_ERR and STP_ERR may both assert in the same cycle.
- P_DATA holds its value between valid frames.
- Changes to PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- RX_IN stuck at 0: each failed stop check is followed by a re-entry to START. STP_ERR pulses once per frame period. No hang.
- Reset mid-frame: the frame is discarded immediately and no strobe is raised.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0; send 0xA5 (data bits 1,0,1,0,0,1,0,1; parity 0; stop 1) -> Data_Valid pulses once, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0.
- Same frame with PAR_TYP=1 and parity bit 1 -> P_DATA=0xA5, valid. Then send parity bit 0 -> PAR_ERR pulses once, Data_Valid stays 0, P_DATA remains 0xA5.
- PAR_EN=0; send 0x3C, then send 0xFF with stop bit forced to 0 -> first frame gives P_DATA=0x3C. Second frame gives STP_ERR pulse only, and P_DATA stays 0x3C.
- Drive RX_IN low for 2 CLK cycles, then high -> start rejected, FSM back in IDLE, no strobes. A following valid 0x5A frame is received correctly.
- Back-to-back frames 0x01 then 0x80 with no idle gap, PAR_EN=0 -> two Data_Valid pulses spaced 10×Prescale cycles apart, with P_DATA=0x01 then 0x80.
- Assert RST during bit 4 of a frame, release it, then send 0xC3 -> no strobe for the aborted frame, then P_DATA=0xC3 with Data_Valid.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 3-point majority-vote bit sampling,
// LSB-first deserialisation with optional parity and one stop bit.
module uart_rx #(
    parameter int unsigned Data_Width    = 8,
    parameter int unsigned Prescale      = 8,
    parameter int unsigned Counter_Width = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [Data_Width-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned TICK_W = (Prescale > 2) ? $clog2(Prescale) : 1;

    localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(Prescale - 1);
    localparam logic [TICK_W-1:0]        TICK_S0   = TICK_W'(Prescale / 2 - 1);
    localparam logic [TICK_W-1:0]        TICK_S1   = TICK_W'(Prescale / 2);
    localparam logic [TICK_W-1:0]        TICK_S2   = TICK_W'(Prescale / 2 + 1);
    localparam logic [TICK_W-1:0]        TICK_EVAL = TICK_W'(Prescale / 2 + 2);
    localparam logic [Counter_Width-1:0] BIT_LAST  = Counter_Width'(Data_Width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    rx_meta;
    logic                    rx_s;
    logic [TICK_W-1:0]       tick;
    logic [Counter_Width-1:0] bit_idx;
    logic                    s0;
    logic                    s1;
    logic                    sample;
    logic                    par_en_l;
    logic                    par_typ_l;
    logic                    par_bad;
    logic [Data_Width-1:0]   shreg;
    logic                    bit_end;
    logic                    start_det;
    logic                    stop_eval;

    // Line synchronizer, preset to idle level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_end    = (tick == TICK_LAST);
        start_det  = 1'b0;
        stop_eval  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == BIT_LAST)) begin
                    state_next = par_en_l ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave early so a following start edge is seen without a gap
                if (tick == TICK_EVAL) begin
                    stop_eval  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tick counter and majority-vote sampler
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick   <= '0;
            s0     <= 1'b1;
            s1     <= 1'b1;
            sample <= 1'b1;
        end else begin
            if ((state == IDLE) || (state_next == IDLE) || bit_end) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end
            if (tick == TICK_S0) s0 <= rx_s;
            if (tick == TICK_S1) s1 <= rx_s;
            if (tick == TICK_S2) sample <= (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        end
    end

    // Frame datapath: config latch, shift register, parity check
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_idx   <= '0;
            shreg     <= '0;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_bad   <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_bad   <= 1'b0;
                bit_idx   <= '0;
            end
            if ((state == DATA) && bit_end) begin
                shreg   <= {sample, shreg[Data_Width-1:1]};
                bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + Counter_Width'(1);
            end
            if ((state == PARITY) && bit_end) begin
                par_bad <= sample ^ (^shreg) ^ par_typ_l;
            end
        end
    end

    // Frame outcome strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (stop_eval) begin
                if (sample && !par_bad) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shreg;
                end else begin
                    PAR_ERR <= par_bad;
                    STP_ERR <= ~sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus randomized frames scored
// against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned PS = 8;
    localparam int unsigned CW = 3;

    typedef struct {
        logic          valid;
        logic          perr;
        logic          serr;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } ev_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_ERR;
    logic          STP_ERR;

    ev_t           obs_q[$];
    ev_t           exp_q[$];
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] last_good;

    uart_rx #(
        .Data_Width   (DW),
        .Prescale     (PS),
        .Counter_Width(CW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every strobe cycle seen on the outputs
    always @(negedge CLK) begin
        if (!RST && (Data_Valid || PAR_ERR || STP_ERR)) begin
            obs_q.push_back('{Data_Valid, PAR_ERR, STP_ERR, P_DATA, cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (PS) @(negedge CLK);
    endtask

    // Drive one frame and record what the receiver should report for it
    task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                              input logic flip_par, input logic stop, input logic scramble);
        logic perr;
        PAR_EN  = pe;
        PAR_TYP = pt;
        send_bit(1'b0);
        if (scramble) begin
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
        end
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (pe) send_bit((^d) ^ pt ^ flip_par);
        send_bit(stop);
        perr = pe && flip_par;
        if (stop && !perr) begin
            last_good = d;
            exp_q.push_back('{1'b1, 1'b0, 1'b0, d, 0});
        end else begin
            exp_q.push_back('{1'b0, perr, ~stop, last_good, 0});
        end
    endtask

    task automatic drain(input string tag);
        ev_t o;
        ev_t e;
        RX_IN = 1'b1;
        repeat (3 * PS) @(negedge CLK);
        check({tag, "_cnt"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(o.valid), 32'(e.valid));
            check({tag, "_perr"},  32'(o.perr),  32'(e.perr));
            check({tag, "_serr"},  32'(o.serr),  32'(e.serr));
            check({tag, "_data"},  32'(o.data),  32'(e.data));
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_hold"}, 32'(P_DATA), 32'(last_good));
    endtask

    task automatic do_reset();
        RST   = 1'b1;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_strobes", {29'h0, Data_Valid, PAR_ERR, STP_ERR}, 32'h0);
        RST       = 1'b0;
        last_good = '0;
        obs_q.delete();
        exp_q.delete();
        repeat (2 * PS) @(negedge CLK);
    endtask

    initial begin
        int          diff;
        int          stp_cnt;
        int          val_cnt;
        logic [DW-1:0] abort_d;
        logic        prev_bad_stop;
        logic [DW-1:0] d;
        logic        pe;
        logic        pt;
        logic        fp;
        logic        st;

        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        @(negedge CLK);
        do_reset();

        // Even parity, good frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("even_ok");

        // Odd parity: good frame, then wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_bit(1'b1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain("odd");

        // No parity: good frame, then stop bit forced low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("stop_err");

        // Short low glitch must be rejected
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (2 * PS) @(negedge CLK);
        check("glitch_none", obs_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("after_glitch");

        // Back-to-back frames, spacing of the valid strobes
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        RX_IN = 1'b1;
        repeat (2 * PS) @(negedge CLK);
        diff = (obs_q.size() >= 2) ? int'(obs_q[1].cyc - obs_q[0].cyc) : -1;
        check("b2b_spacing", 32'(diff), 32'(10 * PS));
        drain("b2b");

        // Reset during data bit 4 discards the frame
        abort_d = 8'h96;
        PAR_EN  = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_d[i]);
        RX_IN = abort_d[4];
        repeat (PS / 2) @(negedge CLK);
        do_reset();
        check("abort_none", obs_q.size(), 0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("after_abort");

        // Line stuck low: one stop error per frame period, never a valid
        RX_IN = 1'b0;
        repeat (4 * 10 * PS + 5 * PS) @(negedge CLK);
        stp_cnt = 0;
        val_cnt = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].serr) stp_cnt++;
            if (obs_q[i].valid) val_cnt++;
        end
        check("stuck_stp_cnt", 32'(stp_cnt), 32'd4);
        check("stuck_valid_cnt", 32'(val_cnt), 32'd0);
        do_reset();

        // Randomized frames, including mid-frame config changes and no-gap runs
        prev_bad_stop = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 5; f++) begin
                int unsigned gap;
                gap = $urandom_range(3, 0);
                if (prev_bad_stop && gap < 2) gap = 2;
                for (int g = 0; g < int'(gap); g++) send_bit(1'b1);
                d  = DW'($urandom);
                pe = 1'($urandom);
                pt = 1'($urandom);
                fp = ($urandom_range(3, 0) == 0);
                st = ($urandom_range(4, 0) != 0);
                send_frame(d, pe, pt, fp, st, 1'($urandom));
                prev_bad_stop = ~st;
            end
            drain("rand");
            prev_bad_stop = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
